// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive/transmit blocks.
//   - Frame bit positions for an 11-bit frame: start, 8 data bits, parity, stop.
//   - FSM state encoding of the receive frame buffer.
//   - Width of one stored FIFO entry: {ferror, perror, data[7:0]}.
package uart_pkg;

  localparam int unsigned START_BIT  = 0;
  localparam int unsigned DATA_LSB   = 1;
  localparam int unsigned DATA_MSB   = 8;
  localparam int unsigned PARITY_BIT = 9;
  localparam int unsigned STOP_BIT   = 10;

  localparam int unsigned FRAME_W    = 11;
  localparam int unsigned ENTRY_W    = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_PUSH  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous level, with a
// registered copy of the synchronized level for rising-edge detection.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset; all flops clear to 0, so an
//             input already high at release produces one rising edge
//   async_in  level from another clock domain
//   sync_out  synchronized level
//   rise      one-cycle pulse on a rising edge of sync_out
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// uart_rx_frame_buffer: checks start/stop/parity of received 11-bit frames,
// and queues {ferror, perror, data} in a DEPTH-entry FIFO read out through a
// valid/ready handshake.
// Parameters:
//   DEPTH       FIFO entries (power of two, 2..64)
//   PARITY_ODD  0 = even parity over data+parity, 1 = odd
// Ports:
//   clk, reset            system clock; asynchronous active-low reset
//   Rx_frame, Rx_valid    frame and its (asynchronous) availability level
//   Rx_FERROR             frame error from the reception stage
//   rd_data/perror/ferror head entry, valid while rd_valid = 1
//   rd_valid, rd_ready    read handshake; pop when both high
//   full, count           registered occupancy status
//   overrun               sticky; a frame was dropped on a full FIFO
// Build option: define UART_RX_PARITY_CHECK_EN to build the parity checker;
// otherwise the stored parity error flag is constant 0.
module uart_rx_frame_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FRAME_W-1:0]       Rx_frame,
  input  logic                     Rx_valid,
  input  logic                     Rx_FERROR,
  output logic [7:0]               rd_data,
  output logic                     rd_perror,
  output logic                     rd_ferror,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rx_state_e state_q, state_d;

  logic               frame_rise;
  logic               valid_sync;
  logic               capture;
  logic               check;
  logic               push_req;
  logic               push;
  logic               pop;

  logic [FRAME_W-1:0] frame_q;
  logic               fin_q;
  logic               ferror_q;
  logic               perror_q;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               full_q;
  logic               overrun_q;
  logic [ENTRY_W-1:0] head;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (Rx_valid),
    .sync_out (valid_sync),
    .rise     (frame_rise)
  );

  // Only the edge matters; the level itself is not used here.
  logic unused_sync;
  assign unused_sync = valid_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Events outside S_IDLE are ignored: the receiver cannot deliver a new
  // frame within the three-cycle capture/check/push sequence.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    check    = 1'b0;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_rise) begin
          capture = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        check   = 1'b1;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        push_req = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q  <= '0;
      fin_q    <= 1'b0;
      ferror_q <= 1'b0;
    end else begin
      if (capture) begin
        frame_q <= Rx_frame;
        fin_q   <= Rx_FERROR;
      end
      if (check) begin
        ferror_q <= fin_q | frame_q[START_BIT] | ~frame_q[STOP_BIT];
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     perror_q <= 1'b0;
    else if (check) perror_q <= (^frame_q[PARITY_BIT:DATA_LSB]) ^ PARITY_ODD;
  end
`else
  assign perror_q = 1'b0;
  logic unused_parity;
  assign unused_parity = frame_q[PARITY_BIT] ^ PARITY_ODD;
`endif

  // A pop on the same edge frees the slot, so a push into a full FIFO still
  // succeeds; an empty FIFO has no bypass because rd_valid is still low.
  assign pop     = (count_q != '0) && rd_ready;
  assign push    = push_req && (!full_q || pop);
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ferror_q, perror_q, frame_q[DATA_MSB:DATA_LSB]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (push_req && !push) overrun_q <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign rd_data   = head[7:0];
  assign rd_perror = head[8];
  assign rd_ferror = head[9];
  assign rd_valid  = (count_q != '0);
  assign full      = full_q;
  assign count     = count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
module tb_uart_rx_frame_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Rx_frame;
  logic        Rx_valid;
  logic        Rx_FERROR;
  logic [7:0]  rd_data;
  logic        rd_perror;
  logic        rd_ferror;
  logic        rd_valid;
  logic        rd_ready;
  logic        full;
  logic [3:0]  count;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  logic [9:0] sb[$];

  uart_rx_frame_buffer #(.DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .Rx_frame  (Rx_frame),
    .Rx_valid  (Rx_valid),
    .Rx_FERROR (Rx_FERROR),
    .rd_data   (rd_data),
    .rd_perror (rd_perror),
    .rd_ferror (rd_ferror),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .full      (full),
    .count     (count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame with correct even parity unless pflip is set.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip,
                                     input logic stop, input logic start);
    return {stop, (^d) ^ pflip, d, start};
  endfunction

  function automatic logic [9:0] exp_entry(input logic [10:0] f, input logic fe);
    logic pe;
`ifdef UART_RX_PARITY_CHECK_EN
    pe = ^f[9:1];
`else
    pe = 1'b0;
`endif
    return {fe | f[0] | ~f[10], pe, f[8:1]};
  endfunction

  task automatic send(input logic [10:0] f, input logic fe, input bit accept);
    @(posedge clk); #1;
    Rx_frame  = f;
    Rx_FERROR = fe;
    Rx_valid  = 1'b1;
    if (accept) sb.push_back(exp_entry(f, fe));
    repeat (5) @(posedge clk);
    #1 Rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_valid"}, rd_valid, 1'b1);
      chk({tag, "_entry"}, {rd_ferror, rd_perror, rd_data}, sb[0]);
      rd_ready = 1'b1;
      @(posedge clk);
      void'(sb.pop_front());
    end
    #1 rd_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_empty"}, rd_valid, 1'b0);
    chk({tag, "_count0"}, count, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_full", full, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    Rx_frame  = '0;
    Rx_valid  = 1'b0;
    Rx_FERROR = 1'b0;
    rd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", rd_valid, 1'b0);
    chk("reset_count", count, 0);
    chk("reset_full", full, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // Good frame, exact latency: write happens on the fifth edge after raise.
    @(posedge clk); #1;
    Rx_frame  = mk(8'hA5, 1'b0, 1'b1, 1'b0);
    Rx_FERROR = 1'b0;
    Rx_valid  = 1'b1;
    sb.push_back(exp_entry(Rx_frame, 1'b0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lat_before", rd_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", rd_valid, 1'b1);
    chk("good_data", rd_data, 8'hA5);
    chk("good_perror", rd_perror, 1'b0);
    chk("good_ferror", rd_ferror, 1'b0);
    chk("good_count", count, 1);
    #1 Rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    drain("good");

    // Parity flip, bad stop bit, external frame error.
    send(mk(8'hA5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    @(negedge clk);
`ifdef UART_RX_PARITY_CHECK_EN
    chk("par_perror", rd_perror, 1'b1);
`else
    chk("par_perror", rd_perror, 1'b0);
`endif
    send(11'b0_0_01011010_0, 1'b0, 1'b1);
    send(mk(8'h3C, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
    send(mk(8'h81, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1);
    @(negedge clk);
    chk("err_count", count, 4);
    drain("err");

    // Two fill/drain passes with overflow; pointers start offset so both wrap.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++)
        send(mk(8'(8'h10 * p + i * 8'h13 + 8'h07), 1'b0, 1'b1, 1'b0), 1'b0, 1'b1);
      @(negedge clk);
      chk("fill_full", full, 1'b1);
      chk("fill_count", count, DEPTH);
      chk("fill_overrun", overrun, p != 0);
      send(mk(8'hEE, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
      @(negedge clk);
      chk("drop_overrun", overrun, 1'b1);
      chk("drop_count", count, DEPTH);
      drain("fill");
      chk("after_full", full, 1'b0);
    end
    chk("sticky_overrun", overrun, 1'b1);
    do_reset();

    // Full FIFO, pop on the exact push edge: push must be accepted.
    for (int i = 0; i < DEPTH; i++)
      send(mk(8'(8'hC0 + i), 1'b0, 1'b1, 1'b0), 1'b0, 1'b1);
    @(posedge clk); #1;
    Rx_frame  = mk(8'h5E, 1'b0, 1'b1, 1'b0);
    Rx_FERROR = 1'b0;
    Rx_valid  = 1'b1;
    sb.push_back(exp_entry(Rx_frame, 1'b0));
    repeat (4) @(posedge clk);
    #1 rd_ready = 1'b1;
    @(posedge clk);
    void'(sb.pop_front());
    #1 rd_ready = 1'b0;
    @(negedge clk);
    chk("simul_count", count, DEPTH);
    chk("simul_full", full, 1'b1);
    chk("simul_overrun", overrun, 1'b0);
    Rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    drain("simul");

    // Reset with 3 queued entries and a frame in the check state.
    for (int i = 0; i < 3; i++)
      send(mk(8'(8'h60 + i), 1'b0, 1'b1, 1'b0), 1'b0, 1'b1);
    @(posedge clk); #1;
    Rx_frame = mk(8'h77, 1'b0, 1'b1, 1'b0);
    Rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid", rd_valid, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_overrun", overrun, 1'b0);
    sb.delete();
    Rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("postrst_count", count, 0);
    send(mk(8'h96, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1);
    @(negedge clk);
    chk("postrst_count1", count, 1);
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_buffer.md
# uart_rx_frame_buffer

Downstream stage of the UART receive path: consumes the 11-bit frame and valid/frame-error indications produced by the reception stage and checks start, stop and parity bits. It extracts the data byte and queues it, with per-entry error flags, in a small FIFO. Consumers read it through a valid/ready handshake. It isolates the bit-level receiver from the system-clock consumer and absorbs bursts of back-to-back characters.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- PARITY_ODD, 0: 0 = even parity over data+parity bit, 1 = odd.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- Rx_frame  input  11  received frame; bit 0 start, bits 8:1 data (bit 1 = LSB), bit 9 parity, bit 10 stop.
- Rx_valid  input  1  frame-available level from reception stage; asynchronous to clk.
- Rx_FERROR  input  1  frame error reported by reception stage; held with Rx_frame.
- rd_data  output  8  data byte of head entry.
- rd_perror  output  1  parity error flag of head entry.
- rd_ferror  output  1  framing error flag of head entry.
- rd_valid  output  1  head entry present.
- rd_ready  input  1  consumer accepts head entry.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overrun  output  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- Rx_valid passes through a 2-flop synchronizer. A rising edge of the synchronized level is a frame event.
- FSM states: S_IDLE, S_CHECK, S_PUSH.
  - S_IDLE: on a frame event, capture Rx_frame and Rx_FERROR into holding registers, then go to S_CHECK.
  - S_CHECK: compute ferror = Rx_FERROR | frame[0] | ~frame[10]. Compute perror = (^frame[9:1]) ^ PARITY_ODD. Go to S_PUSH.
  - S_PUSH: if not full, write {ferror, perror, data} at the write pointer. If full, drop the frame and set overrun. Return to S_IDLE.
- Frame events arriving while not in S_IDLE are ignored. The reception stage cannot produce frames faster than 1 per 11 bit periods, so this is not a data-loss case.
- FIFO: circular buffer with pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. count = writes − pops.
  - A pop occurs when rd_valid && rd_ready. The head pointer advances.
  - rd_valid = (count != 0).
  - rd_data/rd_perror/rd_ferror show the head entry combinationally from storage. They are don't-care when rd_valid = 0.
- Simultaneous push and pop:
  - When full: the pop frees a slot and the push succeeds; count is unchanged and overrun is not set.
  - When empty: no bypass. Only the push takes effect, and rd_valid rises the next cycle.
- overrun clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system) sets:
  - FSM to S_IDLE; pointers and count to 0.
  - rd_valid = 0, full = 0, overrun = 0.
  - Synchronizer flops to 0, so an Rx_valid already high at reset release counts as one event.
- Latency: Rx_valid rise sampled at edge 0. Synchronized edge detected at edge 2. Capture at edge 2, S_CHECK at edge 3, write at edge 4. rd_valid is high after edge 4, i.e. 4–5 cycles depending on input phase.
- A pop takes effect at the clock edge where rd_valid && rd_ready. The next head is presented in the following cycle.
- rd_ready may be held high constantly. The block emits one entry per cycle while non-empty.
- full and count are registered, so both update on the edge after a push or pop.
- Reset mid-operation discards all queued entries and any frame in flight.

## Configuration
- UART_RX_PARITY_CHECK_EN
  - Defined: perror is computed as above and stored per entry.
  - Undefined: no parity logic is built. Stored perror is constant 0, rd_perror = 0, and PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg:
  - Frame bit-index constants (START_BIT = 0, DATA_LSB = 1, DATA_MSB = 8, PARITY_BIT = 9, STOP_BIT = 10).
  - FSM state encoding.
  - FIFO entry width constant (10).
- One sub-module: uart_rx_sync, a 2-flop synchronizer with rising-edge detect output. It is reusable on the transmit side.

## Test plan
- Valid frame {stop 1, parity 0, data 0xA5, start 0} with even parity, Rx_FERROR = 0 → after ≤5 cycles, rd_valid = 1, rd_data = 0xA5, rd_perror = 0, rd_ferror = 0, count = 1.
- Same frame with the parity bit flipped → rd_perror = 1 with the macro defined. Without the macro, rd_perror = 0.
- Stop bit 0 (frame 11'b0_0_01011010_0), and separately Rx_FERROR = 1 on a good frame → rd_ferror = 1, and data is still queued.
- With rd_ready = 0, push DEPTH+1 frames → full = 1 and count = DEPTH after DEPTH frames. The last frame is dropped and overrun = 1. Draining returns the first DEPTH bytes in order, with wrap-around verified across two fill/drain passes.
- With full, assert rd_ready on the exact cycle of S_PUSH → the new frame is accepted, count stays DEPTH, and overrun stays 0.
- Assert reset with 3 entries queued and a frame in S_CHECK → rd_valid = 0, count = 0, overrun = 0 immediately. The next frame is received normally.
